// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle adder/subtractor that processes CHUNK bits per
// clock. The carry between chunks travels only through carry_r, so the
// critical path is one CHUNK-bit add regardless of WIDTH.
module seq_chunk_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] z,
   output logic             cout,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t state, state_next;

   logic             accept;     // operation accepted at this edge
   logic             last;       // this edge processes the final chunk
   logic [WIDTH-1:0] a_r;        // latched operand A
   logic [WIDTH-1:0] beff_r;     // latched effective B (b or ~b)
   logic             carry_r;    // carry into the current chunk
   logic [KW-1:0]    k;          // index of the chunk being added
   logic [WIDTH-1:0] psum_r;     // partial sum, filled one chunk per edge
   logic [CHUNK:0]   chunk_sum;  // CHUNK-bit sum plus chunk carry-out
   logic [WIDTH-1:0] sum_full;   // partial sum with the current chunk merged in
   logic             ovf_next;
   int               base;       // bit offset of chunk k

   // Next-state logic and per-edge strobes.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_next = state;
      accept     = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            if (start && !reset) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (k == K_LAST) begin
               last       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Chunk adder: one CHUNK-bit add using only the registered carry.
   always_comb begin
      base      = int'(k) * CHUNK;
      chunk_sum = {1'b0, a_r[base +: CHUNK]}
                + {1'b0, beff_r[base +: CHUNK]}
                + {{CHUNK{1'b0}}, carry_r};
      sum_full  = psum_r;
      sum_full[base +: CHUNK] = chunk_sum[CHUNK-1:0];
      ovf_next  = (a_r[WIDTH-1] == beff_r[WIDTH-1]) &&
                  (sum_full[WIDTH-1] != a_r[WIDTH-1]);
   end

   // State register; reset wins over everything.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Operand latch and chunk-by-chunk accumulation.
   always_ff @(posedge clk) begin
      // NOTE: these registers need no reset; they are always loaded on accept before being read.
      if (accept) begin
         a_r     <= a;
         beff_r  <= sub ? ~b : b;
         carry_r <= sub ? 1'b1 : cin;
         psum_r  <= '0;
         k       <= '0;
      end else if (state == RUN) begin
         psum_r  <= sum_full;
         carry_r <= chunk_sum[CHUNK];
         k       <= k + 1'b1;
      end
   end

   // Visible outputs: results only move at completion or reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= 1'b0;
         done <= 1'b0;
         z    <= '0;
         cout <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         busy <= (state_next == RUN);
         done <= last;
         if (last) begin
            z    <= sum_full;
            cout <= chunk_sum[CHUNK];
            ovf  <= ovf_next;
         end
      end
   end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder: a per-cycle reference model for the
// 32/8 instance, directed vectors with literal expectations, and two 16-bit
// instances for latency and overflow at other chunk sizes.
module tb_seq_chunk_adder;

   localparam int W  = 32;
   localparam int NC = 4;

   logic          clk = 1'b0;
   logic          reset, start, cin, sub;
   logic [W-1:0]  a, b;
   logic          busy, done, cout, ovf;
   logic [W-1:0]  z;

   logic          start16, cin16, sub16;
   logic [15:0]   a16, b16;
   logic          busy_p, done_p, cout_p, ovf_p;
   logic [15:0]   z_p;
   logic          busy_q, done_q, cout_q, ovf_q;
   logic [15:0]   z_q;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
      .busy(busy), .done(done), .z(z), .cout(cout), .ovf(ovf)
   );

   seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut_p (
      .clk(clk), .reset(reset), .start(start16), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
      .busy(busy_p), .done(done_p), .z(z_p), .cout(cout_p), .ovf(ovf_p)
   );

   seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut_q (
      .clk(clk), .reset(reset), .start(start16), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
      .busy(busy_q), .done(done_q), .z(z_q), .cout(cout_q), .ovf(ovf_q)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: whole-word arithmetic, result published NC edges after accept.
   logic         m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
   logic [W-1:0] m_z = '0;
   logic [W-1:0] p_z;
   logic         p_c, p_o;
   int           m_left = 0;

   always @(posedge clk) begin
      logic [W-1:0] beff;
      logic         c;
      logic [W:0]   wide;
      logic [W:0]   sx;
      if (reset) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_z <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
         m_left <= 0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (start) begin
               beff = sub ? ~b : b;
               c    = sub ? 1'b1 : cin;
               wide = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, c};
               sx   = {a[W-1], a} + {beff[W-1], beff} + {{W{1'b0}}, c};
               p_z    <= wide[W-1:0];
               p_c    <= wide[W];
               p_o    <= sx[W] ^ sx[W-1];
               m_busy <= 1'b1;
               m_left <= NC;
            end
         end else if (m_left == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_z    <= p_z;
            m_cout <= p_c;
            m_ovf  <= p_o;
            m_left <= 0;
         end else begin
            m_left <= m_left - 1;
         end
      end
   end

   // Per-cycle comparison of the 32/8 instance against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", busy, m_busy);
         check("done", done, m_done);
         check("z", z, m_z);
         check("cout", cout, m_cout);
         check("ovf", ovf, m_ovf);
      end
   end

   // One operation on the 32/8 instance; returns edges to done and busy-cycle count.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                         input logic tc, input logic ts, output int lat, output int bcnt);
      bit seen = 1'b0;
      @(negedge clk);
      a = ta; b = tb2; cin = tc; sub = ts; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat  = 0;
      bcnt = int'(busy);
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         lat++;
         bcnt += int'(busy);
         if (done) seen = 1'b1;
      end
      check("op_done_seen", seen, 1);
   endtask

   initial begin
      int lat, bcnt, ndone, last_cyc, cyc, lat_p, lat_q;
      bit seen;
      reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_z", z, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      reset = 1'b0;

      // 1 + 1
      run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, lat, bcnt);
      check("t1_latency", lat, 4);
      check("t1_busy_cycles", bcnt, 4);
      check("t1_z", z, 32'h0000_0002);
      check("t1_cout", cout, 0);
      check("t1_ovf", ovf, 0);

      // carry ripples through every chunk
      run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, lat, bcnt);
      check("t2_z", z, 32'h0000_0000);
      check("t2_cout", cout, 1);
      check("t2_ovf", ovf, 0);

      // positive overflow
      run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, bcnt);
      check("t3_z", z, 32'h8000_0000);
      check("t3_cout", cout, 0);
      check("t3_ovf", ovf, 1);

      // 5 - 7, cin must be ignored when subtracting
      run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, lat, bcnt);
      check("t4_z", z, 32'hFFFF_FFFE);
      check("t4_cout", cout, 0);
      check("t4_ovf", ovf, 0);

      // start while busy is ignored
      @(negedge clk);
      a = 32'd1; b = 32'd2; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      a = 32'd100; b = 32'd100;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("t5_done_seen", seen, 1);
      check("t5_z", z, 32'h0000_0003);
      repeat (2) @(negedge clk);
      check("t5_idle", busy, 0);

      // reset at the second RUN edge aborts the operation
      @(negedge clk);
      a = 32'h1234_5678; b = 32'h0000_0001; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t6_busy", busy, 0);
      check("t6_z", z, 0);
      check("t6_cout", cout, 0);
      check("t6_ovf", ovf, 0);
      ndone = 0;
      repeat (8) begin
         @(negedge clk);
         ndone += int'(done);
      end
      check("t6_no_done", ndone, 0);

      // back-to-back stream with start held high
      ndone = 0; last_cyc = 0; cyc = 0;
      @(negedge clk);
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom); start = 1'b1;
      for (int i = 0; i < 200 && ndone < 10; i++) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            ndone++;
            if (ndone > 1) check("t7_spacing", cyc - last_cyc, NC + 1);
            last_cyc = cyc;
            if (ndone == 10) start = 1'b0;
         end
         a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      end
      start = 1'b0;
      check("t7_done_count", ndone, 10);
      repeat (6) @(negedge clk);
      check("t7_idle", busy, 0);

      // 16-bit instances: CHUNK=4 and CHUNK=16
      @(negedge clk);
      a16 = 16'h7FFF; b16 = 16'h0001; cin16 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      lat_p = 0; lat_q = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (done_p && lat_p == 0) lat_p = i;
         if (done_q && lat_q == 0) lat_q = i;
      end
      check("t8_lat_c4", lat_p, 4);
      check("t8_lat_c16", lat_q, 1);
      check("t8_z_c4", z_p, 16'h8000);
      check("t8_z_c16", z_q, 16'h8000);
      check("t8_ovf_c4", ovf_p, 1);
      check("t8_ovf_c16", ovf_q, 1);
      check("t8_cout_c4", cout_p, 0);
      check("t8_cout_c16", cout_q, 0);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global time bound so the run always terminates.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
